// File: rtl/serial_word_scheduler_if.sv
// Bundle between the requesters / SerialCTL side and the serial word scheduler.
// The scheduler is the slave; the environment (requesters plus SerialCTL done
// flag) is the master.
interface serial_word_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic               start;
    logic [DW-1:0]      data;
    logic               done_flag;
    logic               busy;
    logic [IW-1:0]      grant_idx;

    modport master (
        output req, req_data, done_flag,
        input  ack, err, start, data, busy, grant_idx
    );

    modport slave (
        input  req, req_data, done_flag,
        output ack, err, start, data, busy, grant_idx
    );
endinterface

// File: rtl/serial_word_scheduler.sv
// Round-robin scheduler sharing one SerialCTL shifter among NREQ requesters.
// Grants one requester, presents its word on data, holds start for START_CYC
// cycles, then waits for a done_flag rising edge (or a timeout) and acks the
// requester with err flagging the timeout case.
module serial_word_scheduler #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_word_scheduler_if.slave bus
);
    localparam int IW  = $clog2(NREQ);
    localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   grant_q;
    logic [DW-1:0]   data_q;
    logic            start_q;
    logic [NREQ-1:0] ack_q;
    logic            err_q;
    logic            busy_q;
    logic            done_q;
    logic            sticky_q;
    logic [SCW-1:0]  lcnt_q;
    logic [TW-1:0]   wcnt_q;

    logic [IW-1:0]   pick_d;
    logic            pick_vld_d;
    logic            rise_d;

    // Round-robin pick: first set request searching upward from ptr+1 with wrap.
    // The loop runs from the farthest candidate down so the nearest one wins.
    always_comb begin
        pick_d     = '0;
        pick_vld_d = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(ptr_q) + k) % NREQ]) begin
                pick_vld_d = 1'b1;
                pick_d     = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign rise_d = bus.done_flag & ~done_q;

    // Transfer FSM with registered outputs; done edge is tracked from the first
    // launch cycle so an early completion is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= IW'(NREQ - 1);
            grant_q  <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
            lcnt_q   <= '0;
            wcnt_q   <= '0;
        end else begin
            done_q <= bus.done_flag;
            ack_q  <= '0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        grant_q  <= pick_d;
                        data_q   <= bus.req_data[pick_d*DW +: DW];
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        sticky_q <= 1'b0;
                        lcnt_q   <= '0;
                        state_q  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (rise_d) begin
                        sticky_q <= 1'b1;
                    end
                    if (lcnt_q == SCW'(START_CYC - 1)) begin
                        start_q <= 1'b0;
                        wcnt_q  <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        lcnt_q <= lcnt_q + SCW'(1);
                    end
                end
                S_WAIT: begin
                    // Completion takes precedence over a simultaneous timeout.
                    if (sticky_q || rise_d) begin
                        ack_q   <= NREQ'(1) << grant_q;
                        err_q   <= 1'b0;
                        state_q <= S_ACK;
                    end else if (wcnt_q == TW'(TIMEOUT)) begin
                        ack_q   <= NREQ'(1) << grant_q;
                        err_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        wcnt_q <= wcnt_q + TW'(1);
                    end
                end
                S_ACK: begin
                    ptr_q   <= grant_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.start     = start_q;
    assign bus.data      = data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_idx = grant_q;
endmodule

// File: tb/tb_serial_word_scheduler.sv
// Directed plus randomized bench for serial_word_scheduler. Expected grant,
// ack latency and err come from a transaction-level model of the round-robin
// and completion/timeout rules.
module tb_serial_word_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int S    = 2;
    localparam int T    = 20;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   ptr_m;
    logic [31:0] words [NREQ];

    serial_word_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    serial_word_scheduler #(
        .NREQ(NREQ), .DW(DW), .START_CYC(S), .TIMEOUT(T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next grant: first requesting index after the last granted one, wrapping.
    function automatic int model_grant(input logic [NREQ-1:0] rq, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_words();
        bus.req_data = {words[3], words[2], words[1], words[0]};
    endtask

    // One transfer. Cycle 0 is the first cycle after the edge that samples req.
    // c = cycle in which done_flag rises (-1 = never); pre_high keeps it high
    // from before launch; drop releases req during WAIT.
    task automatic do_xfer(input logic [NREQ-1:0] rq, input int c,
                           input bit pre_high, input bit drop, input string tag);
        int g;
        int ack_cyc;
        bit exp_err;
        logic [31:0] exp_data;
        g = model_grant(rq, ptr_m);
        if (c >= 0 && c + 1 <= S + T + 1) begin
            exp_err = 1'b0;
            ack_cyc = (c + 1 > S + 1) ? c + 1 : S + 1;
        end else begin
            exp_err = 1'b1;
            ack_cyc = S + T + 1;
        end
        exp_data      = words[g];
        bus.req       = rq;
        drive_words();
        bus.done_flag = pre_high;
        for (int k = 0; k <= ack_cyc; k++) begin
            @(posedge clk);
            #1;
            bus.done_flag = pre_high || (c >= 0 && k >= c);
            chk({tag, ".start"}, 32'(bus.start), 32'(k < S));
            chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
            if (k == 0) begin
                chk({tag, ".grant"}, 32'(bus.grant_idx), 32'(g));
                chk({tag, ".data0"}, bus.data, exp_data);
            end
            if (k == 1) begin
                for (int i = 0; i < NREQ; i++) words[i] = $urandom;
                drive_words();
            end
            if (drop && k == S + 1) bus.req = '0;
            if (k == ack_cyc) begin
                chk({tag, ".ack"}, 32'(bus.ack), 32'(1) << g);
                chk({tag, ".err"}, 32'(bus.err), 32'(exp_err));
                chk({tag, ".data_ack"}, bus.data, exp_data);
                chk({tag, ".grant_ack"}, 32'(bus.grant_idx), 32'(g));
            end else begin
                chk({tag, ".no_ack"}, 32'(bus.ack), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".ack_clr"}, 32'(bus.ack), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        bus.done_flag = 1'b0;
        bus.req       = '0;
        ptr_m         = g;
        $display("xfer %s req=%b grant=%0d err=%0d ack_cycle=%0d", tag, rq, g, exp_err, ack_cyc);
    endtask

    initial begin
        int c;
        logic [NREQ-1:0] rq;
        n_assert = 0;
        n_fail   = 0;
        ptr_m    = NREQ - 1;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done_flag = 1'b0;
        for (int i = 0; i < NREQ; i++) words[i] = $urandom;
        drive_words();
        #2;
        chk("rst.start", 32'(bus.start), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.ack", 32'(bus.ack), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        chk("rst.data", bus.data, 32'd0);
        chk("rst.grant", 32'(bus.grant_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, done after launch.
        words[0] = 32'hA5A5_0001;
        do_xfer(4'b0001, 3, 1'b0, 1'b0, "t1");

        // All requesting: strict rotation.
        for (int i = 0; i < 5; i++) do_xfer(4'b1111, 2, 1'b0, 1'b0, "t2_rr");

        // No completion: timeout with err.
        do_xfer(4'b0100, -1, 1'b0, 1'b0, "t3_timeout");

        // Done during launch cycles, first wait cycle, and tie with timeout.
        do_xfer(4'b1010, 1, 1'b0, 1'b0, "t4_launch2");
        do_xfer(4'b1010, 0, 1'b0, 1'b0, "t4_launch1");
        do_xfer(4'b0001, S, 1'b0, 1'b0, "t4_wait1");
        do_xfer(4'b0001, S + T, 1'b0, 1'b0, "t4_tie");
        do_xfer(4'b0001, -1, 1'b1, 1'b0, "t4_prehigh");

        // Reset in WAIT: outputs clear at once, pointer returns to reset value.
        bus.req = 4'b0010;
        drive_words();
        repeat (S + 2) @(posedge clk);
        #1;
        chk("t5.busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5.start", 32'(bus.start), 32'd0);
        chk("t5.busy", 32'(bus.busy), 32'd0);
        chk("t5.ack", 32'(bus.ack), 32'd0);
        chk("t5.grant", 32'(bus.grant_idx), 32'd0);
        ptr_m = NREQ - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1;
        chk("t5.idle", 32'(bus.busy), 32'd0);
        do_xfer(4'b0010, 3, 1'b0, 1'b0, "t5_regrant");

        // Req dropped mid-wait: ack still pulses, then stays idle with no req.
        do_xfer(4'b0100, 6, 1'b0, 1'b1, "t6_drop");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t6.stay_idle", 32'(bus.busy), 32'd0);
            chk("t6.no_start", 32'(bus.start), 32'd0);
        end

        // Randomized transfers against the model.
        for (int n = 0; n < 20; n++) begin
            rq = NREQ'($urandom_range(1, 15));
            c  = int'($urandom_range(0, S + T + 3));
            if (c > S + T + 1) c = -1;
            for (int i = 0; i < NREQ; i++) words[i] = $urandom;
            do_xfer(rq, c, 1'b0, 1'b0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
